// File: rtl/spi_master_tx.sv
// Byte-oriented SPI master transmitter, mode 0, MSB first.
// Optional MISO capture path enabled by SPI_MISO_RX_EN.
module spi_master_tx #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              done,
  output logic              SCK,
  output logic              MOSI,
  output logic              SS
`ifdef SPI_MISO_RX_EN
  ,
  input  logic              MISO,
  output logic [DATA_W-1:0] rx_data
`endif
);

  localparam int CNT_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    GAP
  } state_t;

  state_t state, state_nx;

  logic [CNT_W-1:0]  cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift;
  logic              cnt_last;
  logic              bit_last;
  logic              accept;

  assign cnt_last = (cnt == CNT_LAST);
  assign bit_last = (bit_cnt == BIT_LAST);
  assign accept   = tx_valid && (state == IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state: every non-idle phase lasts one half-period
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (tx_valid) state_nx = SETUP;
      SETUP: if (cnt_last) state_nx = HIGH;
      HIGH:  if (cnt_last) state_nx = LOW;
      LOW: begin
        if (cnt_last) state_nx = bit_last ? HOLD : HIGH;
      end
      HOLD:  if (cnt_last) state_nx = GAP;
      GAP:   if (cnt_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decoded from the current phase
  always_comb begin
    tx_ready = 1'b0;
    done     = 1'b0;
    SS       = 1'b0;
    SCK      = 1'b0;
    MOSI     = 1'b0;
    unique case (state)
      IDLE: begin
        tx_ready = 1'b1;
        SS       = 1'b1;
      end
      SETUP: MOSI = shift[DATA_W-1];
      HIGH: begin
        SCK  = 1'b1;
        MOSI = shift[DATA_W-1];
      end
      LOW:  MOSI = shift[DATA_W-1];
      HOLD: MOSI = shift[DATA_W-1];
      GAP: begin
        SS   = 1'b1;
        done = (cnt == '0);
      end
      default: ;
    endcase
  end

  // Half-period timer, bit counter and tx shifter
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      if (state_nx != state || state == IDLE)
        cnt <= '0;
      else if (!cnt_last)
        cnt <= cnt + CNT_W'(1);
      if (accept) begin
        shift   <= tx_data;
        bit_cnt <= '0;
      end else begin
        if (state == HIGH && state_nx == LOW && !bit_last)
          shift <= shift << 1;
        if (state == LOW && state_nx == HIGH)
          bit_cnt <= bit_cnt + BIT_W'(1);
      end
    end
  end

`ifdef SPI_MISO_RX_EN
  logic [DATA_W-1:0] rx_shift;

  // MISO sampled entering HIGH; word published entering GAP
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_shift <= '0;
      rx_data  <= '0;
    end else begin
      if (state_nx == HIGH && state != HIGH)
        rx_shift <= DATA_W'({rx_shift, MISO});
      if (state_nx == GAP && state != GAP)
        rx_data <= rx_shift;
    end
  end
`endif

endmodule
